bcd_binary_converter: RTL and testbench
=======================================

Name: bcd_binary_converter

Overview:
Sequential BCD-to-binary converter; the inverse of the score path's binary-to-BCD stage. Takes a packed multi-digit BCD value (e.g. a keypad-entered difficulty or a high-score value restored from display format) and produces its binary equivalent using iterative reverse double-dabble: one right shift plus digit correction per clock. Uses a valid/ready handshake on both sides and sits between input-decode logic and the game-control FSM.

Parameters:
DIGITS, 3, number of BCD digits on the input; the input is 4*DIGITS bits wide.
BIN_W, 10, binary output width; must satisfy 2^BIN_W >= 10^DIGITS, and is also the number of shift cycles.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high; clears all state.
in_valid  input  1  bcd_in is valid.
in_ready  output  1  block can accept; high only in IDLE.
bcd_in  input  4*DIGITS  packed BCD; digit 0 in bits [3:0].
out_valid  output  1  bin_out (and err) are valid.
out_ready  input  1  consumer accepts the result.
bin_out  output  BIN_W  binary result.
err  output  1  input had an invalid digit (only with the optional feature).

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; bin_out=0; err=0; shift counter=0; internal registers=0.
- States: IDLE, CONVERT, DONE.
- IDLE: in_ready=1. When in_valid=1 on a rising edge, the block loads bcd_in into the BCD shift register, clears the binary accumulator and the counter, and moves to CONVERT.
- CONVERT: each edge shifts {bcd_reg, bin_acc} right by 1. The LSB of bcd_reg enters the MSB of bin_acc. After the shift, every 4-bit digit of bcd_reg that is >=8 has 3 subtracted from it (all digits in parallel, 4-bit arithmetic). The counter increments.
- When the counter reaches BIN_W-1 and that shift completes, the block moves to DONE. bin_out is registered from bin_acc.
- Latency: out_valid rises exactly BIN_W edges after the accepting edge (10 for the default parameters). in_ready=0 for the whole conversion.
- DONE: out_valid=1. bin_out and err are held stable until out_ready=1 on an edge; on that edge the block returns to IDLE and out_valid=0. A new input cannot be accepted on the same edge; throughput is one conversion per BIN_W+2 cycles minimum.
- in_valid is ignored outside IDLE. bcd_in may change freely once it has been loaded.
- For valid input, bin_out equals the decimal value exactly. For example, 999 gives 1111100111b. After BIN_W shifts the residual bcd_reg is 0.
- Reset mid-CONVERT or mid-DONE: the result is discarded immediately and no out_valid is produced.

Optional Feature:
BCD_DIGIT_CHECK_EN:
- Defined: on acceptance, any input digit >9 is latched as an error. The conversion still runs the full BIN_W cycles, so latency is unchanged. In DONE, err=1 and bin_out is forced to 0.
- Not defined: err is tied to 0. Invalid digits pass through the algorithm unchecked; the result is deterministic but meaningless.

Decomposition:
- Shared package (game_pkg): state encoding constants (ST_IDLE, ST_CONVERT, ST_DONE), the BCD digit width constant (4), and the correction constants (threshold 8, subtract 3).
- One natural sub-module: bcd_digit_adjust. It is a combinational 4-bit "if >=8 subtract 3" cell, instantiated DIGITS times via generate.

Test Plan:
- Reset, then bcd_in=12'h000 with in_valid -> out_valid after 10 edges, bin_out=0, err=0.
- bcd_in=12'h999 -> bin_out=10'd999 (1111100111b); bcd_in=12'h255 -> bin_out=10'd255; sweep all 000..999 against a reference model.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> bin_out stable, in_ready=0, and in_valid pulses are ignored. Release -> IDLE next edge, in_ready=1.
- Assert reset at the 5th CONVERT cycle of 12'h512 -> in_ready=1 and out_valid=0 immediately. A new 12'h007 then yields bin_out=7.
- BCD_DIGIT_CHECK_EN defined, bcd_in=12'h1A3 -> after 10 edges out_valid=1, err=1, bin_out=0. Without the macro -> err=0.
- Back-to-back: 12'h123 then 12'h456 with out_ready held at 1 -> results 123 and 456, each with 10-edge latency and one idle gap.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants for the game datapath: converter FSM encoding and BCD
// digit correction values.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } conv_state_e;

  localparam int          DIGIT_W    = 4;
  localparam logic [3:0]  ADJ_THRESH = 4'd8;
  localparam logic [3:0]  ADJ_SUB    = 4'd3;
  localparam logic [3:0]  DIGIT_MAX  = 4'd9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble correction cell: after a right shift, a digit that
// picked up a weight-8 bit from its upper neighbour is brought back by 3.
module bcd_digit_adjust
  import game_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= ADJ_THRESH) ? digit_i - ADJ_SUB : digit_i;

endmodule

// File: rtl/bcd_binary_converter.sv
// Iterative BCD-to-binary converter, one shift per clock, valid/ready on both
// sides. Optional BCD_DIGIT_CHECK_EN flags inputs containing digits above 9.
module bcd_binary_converter
  import game_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BIN_W-1:0]          bin_out,
  output logic                      err
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  conv_state_e        state_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BIN_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIN_W-1:0]   bin_q;
  logic               in_ready_q;
  logic               out_valid_q;

  // {bcd, acc} shifted right as one word, then every digit corrected
  logic [BCD_W-1:0]   bcd_shr;
  logic [BCD_W-1:0]   bcd_d;
  logic [BIN_W-1:0]   acc_d;

  assign bcd_shr = bcd_q >> 1;
  assign acc_d   = {bcd_q[0], acc_q[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (bcd_shr[g*DIGIT_W +: DIGIT_W]),
      .digit_o (bcd_d[g*DIGIT_W +: DIGIT_W])
    );
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic [DIGITS-1:0] bad_dig;
  logic              flag_q;
  logic              err_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_chk
    assign bad_dig[g] = bcd_in[g*DIGIT_W +: DIGIT_W] > DIGIT_MAX;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && in_valid)
        flag_q <= |bad_dig;
      if (state_q == ST_CONVERT && cnt_q == CNT_LAST)
        err_q <= flag_q;
      else if (state_q == ST_DONE && out_ready)
        err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bcd_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      bin_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            bcd_q      <= bcd_in;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          bcd_q <= bcd_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
`ifdef BCD_DIGIT_CHECK_EN
            bin_q <= flag_q ? '0 : acc_d;
`else
            bin_q <= acc_d;
`endif
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bin_out   = bin_q;

endmodule

// File: tb/tb_bcd_binary_converter.sv
// Scoreboard bench for bcd_binary_converter: driver queues expected results,
// a negedge monitor checks value, error flag and latency on each output.
module tb_bcd_binary_converter;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  bcd_binary_converter #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic             err;
    logic             chk_bin;
    int               acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   prev_acc = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: latency on rising out_valid, value/err on handshake
  always @(negedge clk) begin
    if (out_valid && !ov_prev) begin
      if (sb.size() == 0) chk("spurious_out_valid", 32'd1, 32'd0);
      else chk("latency", cyc - sb[0].acc_cyc, BIN_W);
    end
    if (out_valid && out_ready && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.chk_bin) chk("bin_out", bin_out, e.bin);
      chk("err", err, e.err);
    end
    ov_prev = out_valid;
  end

  // called in the slot just after a rising edge
  task automatic send(input logic [11:0] v, input logic [BIN_W-1:0] eb,
                      input logic ee, input logic cb);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'd0, 32'd1);
      return;
    end
    in_valid = 1'b1;
    bcd_in   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.bin = eb; e.err = ee; e.chk_bin = cb; e.acc_cyc = cyc;
    sb.push_back(e);
    prev_acc = last_acc;
    last_acc = cyc;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    logic [11:0] v;
    int n;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bin_out", bin_out, 0);
    chk("rst_err", err, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // directed vectors
    send(12'h000, 10'd0,   1'b0, 1'b1);
    drain();
    send(12'h999, 10'd999, 1'b0, 1'b1);
    drain();
    send(12'h255, 10'd255, 1'b0, 1'b1);
    drain();
    send(12'h100, 10'd100, 1'b0, 1'b1);
    drain();
    send(12'h080, 10'd80,  1'b0, 1'b1);
    drain();

    // backpressure
    out_ready = 1'b0;
    send(12'h999, 10'd999, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_out_valid", out_valid, 1);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      bcd_in   = 12'h111;
      @(posedge clk); #1;
      if (i % 5 == 0) begin
        chk("bp_bin_stable", bin_out, 999);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid_hold", out_valid, 1);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_queue_empty", sb.size(), 0);

    // reset in the 5th convert cycle, result must vanish
    send(12'h512, 10'd512, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    sb.delete();
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    send(12'h007, 10'd7, 1'b0, 1'b1);
    drain();

    // invalid digit
`ifdef BCD_DIGIT_CHECK_EN
    send(12'h1A3, 10'd0, 1'b1, 1'b1);
`else
    send(12'h1A3, 10'd0, 1'b0, 1'b0);
`endif
    drain();

    // back-to-back
    send(12'h123, 10'd123, 1'b0, 1'b1);
    send(12'h456, 10'd456, 1'b0, 1'b1);
    chk("b2b_gap", last_acc - prev_acc, BIN_W + 2);
    drain();

    // full sweep against decimal reference
    for (int i = 0; i < 1000; i++) begin
      v = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
      send(v, BIN_W'(i), 1'b0, 1'b1);
    end
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
